// File: rtl/temporal_mxu_pkg.sv
// temporal_mxu_pkg: shared FSM state type and unary-digit helpers for the temporal matrix unit
package temporal_mxu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
    return v[31] ? -v : v;
  endfunction
  function automatic logic [31:0] unary_digit(input logic [31:0] mag, input logic [31:0] c, input logic [31:0] step);
    return mag <= c ? 32'd0 : (mag - c > step ? step : mag - c);
  endfunction
endpackage

// File: rtl/unary_mac_node.sv
// unary_mac_node: one output accumulator fed by a unary digit of A and a binary element of B
module unary_mac_node #(
  parameter int BIT_WIDTH = 4,
  parameter int STEP_LOG2 = 1,
  parameter int ACC_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [STEP_LOG2:0]   d_i,
  input  logic                 neg_i,
  input  logic [BIT_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] acc_o
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d, prod;
  always_comb begin
    prod = {{(ACC_WIDTH-BIT_WIDTH){b_i[BIT_WIDTH-1]}}, b_i} * {{(ACC_WIDTH-STEP_LOG2-1){1'b0}}, d_i};
    acc_d = clear_i ? '0 : !en_i ? acc_q : neg_i ? acc_q - prod : acc_q + prod;
  end
  always_ff @(posedge clk) acc_q <= reset ? '0 : acc_d;
  assign acc_o = acc_q;
endmodule

// File: rtl/temporal_mxu_gen.sv
// temporal_mxu_gen: signed OUT = A x B with A streamed as early-terminating unary digits per K column
module temporal_mxu_gen
  import temporal_mxu_pkg::*;
#(
  parameter int DIM_M = 4,
  parameter int DIM_K = 4,
  parameter int DIM_N = 4,
  parameter int BIT_WIDTH = 4,
  parameter int STEP_LOG2 = 1,
  parameter int ACC_WIDTH = 2*BIT_WIDTH + $clog2(DIM_K)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [DIM_M-1:0][DIM_K-1:0][BIT_WIDTH-1:0] A,
  input  logic [DIM_K-1:0][DIM_N-1:0][BIT_WIDTH-1:0] B,
  output logic busy,
  output logic out_valid,
  output logic [DIM_M-1:0][DIM_N-1:0][ACC_WIDTH-1:0] out,
  output logic [$clog2(DIM_K*(2**BIT_WIDTH)+1)-1:0] cycles
);
  localparam int STEP = 1 << STEP_LOG2;
  localparam int KW = DIM_K > 1 ? $clog2(DIM_K) : 1;
  localparam int CTW = BIT_WIDTH + 1;
  localparam int CW = $clog2(DIM_K*(2**BIT_WIDTH)+1);
  state_t state_q, state_d;
  logic [DIM_M-1:0][DIM_K-1:0][BIT_WIDTH-1:0] a_q, a_d;
  logic [DIM_K-1:0][DIM_N-1:0][BIT_WIDTH-1:0] b_q, b_d;
  logic [KW-1:0] k_q, k_d;
  logic [CTW-1:0] c_q, c_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic [DIM_M-1:0][BIT_WIDTH-1:0] mag;
  logic [DIM_M-1:0][STEP_LOG2:0] d;
  logic [DIM_M-1:0] neg;
  logic phase_end, last, accept, run;
  // Per-row digit and the all-rows-consumed reduction that ends a phase early
  always_comb begin
    phase_end = 1'b1;
    for (int m = 0; m < DIM_M; m++) begin
      mag[m] = BIT_WIDTH'(abs_mag(32'($signed(a_q[m][k_q]))));
      d[m] = (STEP_LOG2+1)'(unary_digit(32'(mag[m]), 32'(c_q), 32'(STEP)));
      neg[m] = a_q[m][k_q][BIT_WIDTH-1];
      if (32'(mag[m]) > 32'(c_q) + 32'(STEP)) phase_end = 1'b0;
    end
  end
  always_comb begin
    run = state_q == RUN;
    accept = start && !run;
    last = phase_end && k_q == KW'(DIM_K-1);
    state_d = run ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    a_d = accept ? A : a_q;
    b_d = accept ? B : b_q;
    k_d = (!run || last) ? '0 : phase_end ? k_q + 1'b1 : k_q;
    c_d = (run && !phase_end) ? c_q + CTW'(STEP) : '0;
    cycles_d = accept ? '0 : run ? cycles_q + 1'b1 : cycles_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
      c_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      k_q <= k_d;
      c_q <= c_d;
      cycles_q <= cycles_d;
    end
  end
  always_comb begin
    busy = state_q == RUN;
    out_valid = state_q == DONE;
    cycles = cycles_q;
  end
  for (genvar m = 0; m < DIM_M; m++) begin : g_row
    for (genvar n = 0; n < DIM_N; n++) begin : g_col
      unary_mac_node #(.BIT_WIDTH(BIT_WIDTH), .STEP_LOG2(STEP_LOG2), .ACC_WIDTH(ACC_WIDTH)) u_node (
        .clk(clk),
        .reset(reset),
        .clear_i(accept),
        .en_i(run),
        .d_i(d[m]),
        .neg_i(neg[m]),
        .b_i(b_q[k_q][n]),
        .acc_o(out[m][n])
      );
    end
  end
endmodule
